// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encodings and counter sizing for the serializer
package piso_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit-count width for a word of w bits; never below 1 so a counter always exists.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        if (cw < 1) begin
            cw = 1;
        end
        return cw;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - mod-WIDTH up-counter with clear, enable and terminal-count flag
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, counter returns to 0
//   clr    synchronous clear to 0, wins over en
//   en     advance by one; wraps to 0 after WIDTH-1
//   tc     high while the count equals WIDTH-1
module bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            // Wrap explicitly so a non-power-of-two WIDTH still stays within 0..WIDTH-1.
            cnt_d = tc ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out converter with valid/ready on both sides
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   din         parallel word, sampled only on the load accept edge
//   load_valid  din is offered for loading
//   load_ready  a word can be accepted this cycle (combinational)
//   sout        current serial bit (0 when idle)
//   sout_valid  sout holds a valid bit
//   sout_ready  downstream consumes sout this cycle
//   done        one-cycle pulse after the last bit of a word is consumed
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             done_q;
    logic             done_d;

    logic             in_shift;
    logic             consume;
    logic             last_consume;
    logic             load_fire;
    logic             tc;
    logic             out_bit;

    assign in_shift     = (state_q == ST_SHIFT);
    assign consume      = in_shift && sout_ready;
    assign last_consume = consume && tc;

    // Opening the load port on the last-bit edge lets the next word follow with no gap bit.
    assign load_ready   = !in_shift || last_consume;
    assign load_fire    = load_valid && load_ready;

    assign out_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign sout         = in_shift && out_bit;
    assign sout_valid   = in_shift;
    assign done         = done_q;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (reset),
        .clr   (load_fire),
        .en    (consume),
        .tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        done_d  = last_consume;

        case (state_q)
            ST_IDLE: begin
                if (load_fire) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (load_fire) begin
                    state_d = ST_SHIFT;
                end else if (last_consume) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_fire) begin
            shreg_d = din;
        end else if (consume) begin
            // Shift toward the output end with zero fill so an idle register drains to 0.
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer, MSB-first and LSB-first instances
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] din = 4'b0000;
    logic       load_valid = 1'b0;
    logic       sout_ready = 1'b0;
    logic       sel = 1'b0;

    logic       load_ready_m, sout_m, sout_valid_m, done_m;
    logic       load_ready_l, sout_l, sout_valid_l, done_l;
    logic       m_ready, m_sout, m_valid, m_done;

    int         vectors = 0;
    int         miscompares = 0;

    bit         q[$];
    bit         done_exp = 1'b0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready_m),
        .sout       (sout_m),
        .sout_valid (sout_valid_m),
        .sout_ready (sout_ready),
        .done       (done_m)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready_l),
        .sout       (sout_l),
        .sout_valid (sout_valid_l),
        .sout_ready (sout_ready),
        .done       (done_l)
    );

    assign m_ready = sel ? load_ready_l : load_ready_m;
    assign m_sout  = sel ? sout_l       : sout_m;
    assign m_valid = sel ? sout_valid_l : sout_valid_m;
    assign m_done  = sel ? done_l       : done_m;

    task automatic chk(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (lsb_inst=%0b t=%0t): got %b, expected %b", nm, sel, $time, act, exp);
        end
    endtask

    // Reference model: the queue holds the bits still owed for the word on the link.
    always @(negedge clk) begin
        bit exp_ready;
        bit consume;
        if (!reset) begin
            chk("reset_sout", m_sout, 1'b0);
            chk("reset_sout_valid", m_valid, 1'b0);
            chk("reset_done", m_done, 1'b0);
            q.delete();
            done_exp = 1'b0;
        end else begin
            chk("done", m_done, done_exp);
            chk("sout_valid", m_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("sout", m_sout, q[0]);
            end
            exp_ready = (q.size() == 0) || (q.size() == 1 && sout_ready);
            chk("load_ready", m_ready, exp_ready);
            consume  = (q.size() != 0) && sout_ready;
            done_exp = consume && (q.size() == 1);
            if (consume) begin
                void'(q.pop_front());
            end
            if (load_valid && exp_ready) begin
                for (int i = 0; i < 4; i++) begin
                    q.push_back(sel ? din[i] : din[3 - i]);
                end
            end
        end
    end

    task automatic drive(input logic lv, input logic [3:0] d, input logic sr, input logic rs);
        @(posedge clk);
        #1;
        load_valid = lv;
        din        = d;
        sout_ready = sr;
        reset      = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 4'($urandom), 1'b1, 1'b1);
        end
    endtask

    initial begin
        // Reset held with random inputs, then released.
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        end
        idle(2);

        // Single word, continuous ready.
        drive(1'b1, 4'b1110, 1'b1, 1'b1);
        idle(6);

        // Backpressure for 3 cycles after the first bit.
        drive(1'b1, 4'b1001, 1'b1, 1'b1);
        drive(1'b0, 4'b0000, 1'b1, 1'b1);
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        idle(6);

        // Back-to-back words: second word held valid until the last-bit edge.
        drive(1'b1, 4'b1100, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'b1001, 1'b1, 1'b1);
        end
        idle(6);

        // Reset mid-word, then a clean word with mid-word load attempts.
        drive(1'b1, 4'b0011, 1'b1, 1'b1);
        drive(1'b0, 4'b0000, 1'b1, 1'b1);
        drive(1'b0, 4'b0000, 1'b1, 1'b1);
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 4'b0001, 1'b1, 1'b1);
        drive(1'b1, 4'b1111, 1'b1, 1'b1);
        drive(1'b1, 4'b0110, 1'b1, 1'b1);
        drive(1'b0, 4'b0000, 1'b1, 1'b1);
        idle(6);

        // Randomized traffic on the MSB-first instance.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 99) != 0));
        end
        idle(8);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_msb: %0d bits still expected", q.size());
        end

        // Switch to the LSB-first instance under reset.
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        sel = 1'b1;
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        idle(2);
        drive(1'b1, 4'b0011, 1'b1, 1'b1);
        idle(6);
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 99) != 0));
        end
        idle(8);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_lsb: %0d bits still expected", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
